// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave register-file endpoint.
package spi_pkg;

    localparam int unsigned CMD_W   = 8;
    localparam int unsigned ADDR_W  = 24;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned FRAME_W = CMD_W + ADDR_W + DATA_W;

    localparam logic [CMD_W-1:0] CMD_WR_DEF = 8'h02;
    localparam logic [CMD_W-1:0] CMD_RD_DEF = 8'h03;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StAddr,
        StData,
        StDone,
        StWaitCs
    } state_e;

endpackage

// File: rtl/spi_slave_sync.sv
// Two-flop synchronizer with a configurable reset value.
module spi_slave_sync #(
    parameter int unsigned      WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/spi_slave_regfile_if.sv
// SPI mode-0 slave backing a small 32-bit register file, oversampled in the clk domain.
// Define SPI_SLAVE_MISO_HIZ_EN to tri-state miso whenever it is not actively driven.
module spi_slave_regfile_if
    import spi_pkg::*;
#(
    parameter int unsigned      DEPTH  = 16,
    parameter logic [CMD_W-1:0] CMD_WR = CMD_WR_DEF,
    parameter logic [CMD_W-1:0] CMD_RD = CMD_RD_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cs,
    input  logic             sck,
    input  logic             mosi,
    output logic             miso,
    output logic             frame_done,
    output logic [CMD_W-1:0] frame_cmd
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic cs_s, sck_s, mosi_s;

    spi_slave_sync #(.WIDTH(1), .RESET_VAL(1'b1)) u_sync_cs (
        .clk_i (clk),
        .rst_i (rst),
        .d_i   (cs),
        .q_o   (cs_s)
    );

    spi_slave_sync #(.WIDTH(1), .RESET_VAL(1'b0)) u_sync_sck (
        .clk_i (clk),
        .rst_i (rst),
        .d_i   (sck),
        .q_o   (sck_s)
    );

    spi_slave_sync #(.WIDTH(1), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk_i (clk),
        .rst_i (rst),
        .d_i   (mosi),
        .q_o   (mosi_s)
    );

    state_e              state_q, state_d;
    logic                sck_prev_q, cs_prev_q;
    logic [6:0]          cnt_q, cnt_d;
    logic [DATA_W-1:0]   rx_q, rx_d, rx_next;
    logic [CMD_W-1:0]    cmd_q, cmd_d;
    logic [IDX_W-1:0]    addr_q, addr_d;
    logic                rd_pend_q, rd_pend_d;
    logic [DATA_W-1:0]   tx_q, tx_d;
    logic                miso_q, miso_d;
    logic                frame_done_q, frame_done_d;
    logic [CMD_W-1:0]    frame_cmd_q, frame_cmd_d;
    logic                mem_we;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic sck_rise, sck_fall, cs_fall, cmd_ok, miso_drv;

    // Edges are discarded while deselected so a simultaneous cs rise always wins.
    assign sck_rise = sck_s & ~sck_prev_q & ~cs_s;
    assign sck_fall = ~sck_s & sck_prev_q & ~cs_s;
    assign cs_fall  = ~cs_s & cs_prev_q;
    assign rx_next  = {rx_q[DATA_W-2:0], mosi_s};
    assign cmd_ok   = (cmd_q == CMD_WR) || (cmd_q == CMD_RD);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rx_d         = rx_q;
        cmd_d        = cmd_q;
        addr_d       = addr_q;
        rd_pend_d    = 1'b0;
        tx_d         = tx_q;
        miso_d       = miso_q;
        frame_done_d = 1'b0;
        frame_cmd_d  = frame_cmd_q;
        mem_we       = 1'b0;

        if (rd_pend_q) begin
            tx_d = mem[addr_q];
        end

        case (state_q)
            StIdle: begin
                if (cs_fall) begin
                    cnt_d   = '0;
                    miso_d  = 1'b0;
                    state_d = StCmd;
                end
            end
            StCmd, StAddr, StData: begin
                if (cs_s) begin
                    state_d = StIdle;
                end else if (sck_rise) begin
                    rx_d  = rx_next;
                    cnt_d = cnt_q + 7'd1;
                    if (state_q == StCmd && cnt_q == 7'd7) begin
                        cmd_d   = rx_next[CMD_W-1:0];
                        state_d = StAddr;
                    end else if (state_q == StAddr && cnt_q == 7'd31) begin
                        addr_d    = rx_next[IDX_W-1:0];
                        rd_pend_d = (cmd_q == CMD_RD);
                        state_d   = StData;
                    end else if (state_q == StData && cnt_q == 7'd63) begin
                        // Commit and report on entry to StDone so both are visible together.
                        mem_we       = (cmd_q == CMD_WR);
                        frame_done_d = 1'b1;
                        frame_cmd_d  = cmd_q;
                        state_d      = StDone;
                    end
                end else if (sck_fall && state_q == StData && cmd_q == CMD_RD) begin
                    miso_d = tx_q[DATA_W-1];
                    tx_d   = {tx_q[DATA_W-2:0], 1'b0};
                end
            end
            StDone: begin
                state_d = cs_s ? StIdle : StWaitCs;
            end
            StWaitCs: begin
                if (cs_s) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            sck_prev_q   <= 1'b0;
            cs_prev_q    <= 1'b1;
            cnt_q        <= '0;
            rx_q         <= '0;
            cmd_q        <= '0;
            addr_q       <= '0;
            rd_pend_q    <= 1'b0;
            tx_q         <= '0;
            miso_q       <= 1'b0;
            frame_done_q <= 1'b0;
            frame_cmd_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            sck_prev_q   <= sck_s;
            cs_prev_q    <= cs_s;
            cnt_q        <= cnt_d;
            rx_q         <= rx_d;
            cmd_q        <= cmd_d;
            addr_q       <= addr_d;
            rd_pend_q    <= rd_pend_d;
            tx_q         <= tx_d;
            miso_q       <= miso_d;
            frame_done_q <= frame_done_d;
            frame_cmd_q  <= frame_cmd_d;
            if (mem_we) begin
                mem[addr_q] <= rx_next;
            end
        end
    end

    // Drive only while selected with a known (or not yet decoded) command.
    always_comb begin
        miso_drv = 1'b0;
        if (!rst && !cs_s) begin
            case (state_q)
                StCmd:                           miso_drv = 1'b1;
                StAddr, StData, StDone, StWaitCs: miso_drv = cmd_ok;
                default:                         miso_drv = 1'b0;
            endcase
        end
    end

`ifdef SPI_SLAVE_MISO_HIZ_EN
    assign miso = miso_drv ? miso_q : 1'bz;
`else
    assign miso = miso_drv ? miso_q : 1'b0;
`endif

    assign frame_done = frame_done_q;
    assign frame_cmd  = frame_cmd_q;

endmodule

// File: tb/tb_spi_slave_regfile_if.sv
// Scoreboard bench: the SPI master pushes expected frame results, a monitor checks frame_done.
module tb_spi_slave_regfile_if;

    logic       clk = 1'b0;
    logic       rst, cs, sck, mosi;
    wire        miso;
    logic       frame_done;
    logic [7:0] frame_cmd;

    spi_slave_regfile_if #(.DEPTH(16), .CMD_WR(8'h02), .CMD_RD(8'h03)) dut (
        .clk        (clk),
        .rst        (rst),
        .cs         (cs),
        .sck        (sck),
        .mosi       (mosi),
        .miso       (miso),
        .frame_done (frame_done),
        .frame_cmd  (frame_cmd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  cmd;
        bit          is_rd;
        logic [31:0] rd;
        bit          chk_idle;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] ext_data_out;
    bit          miso_hi;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] cmd, input bit is_rd, input logic [31:0] rd,
                        input bit chk_idle);
        exp_t e;
        e.cmd      = cmd;
        e.is_rd    = is_rd;
        e.rd       = rd;
        e.chk_idle = chk_idle;
        sb.push_back(e);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (frame_done === 1'b1) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_frame_done: got frame_cmd %h expected no pulse",
                             frame_cmd);
                end else begin
                    e = sb.pop_front();
                    check("frame_cmd", {24'h0, frame_cmd}, {24'h0, e.cmd});
                    if (e.is_rd) check("read_data", ext_data_out, e.rd);
                    if (e.chk_idle) check("miso_idle", {31'h0, miso_hi}, 32'h0);
                end
            end
        end
    endtask

    // Half an sck period (6 clk), watching for any driven-high miso while selected.
    task automatic half();
        repeat (6) begin
            @(negedge clk);
            if (!cs && miso === 1'b1) miso_hi = 1'b1;
        end
    endtask

    task automatic spi_frame(input logic [7:0] cmd, input logic [23:0] addr,
                             input logic [31:0] data, input int nbits, input int rst_bit);
        logic [63:0] f;
        f            = {cmd, addr, data};
        ext_data_out = '0;
        miso_hi      = 1'b0;
        @(negedge clk);
        cs  = 1'b0;
        sck = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            mosi = f[63-i];
            if (i == rst_bit) begin
                rst = 1'b1;
                repeat (2) @(negedge clk);
                rst = 1'b0;
            end
            half();
            sck = 1'b1;
            if (i >= 32) ext_data_out = {ext_data_out[30:0], miso};
            half();
            sck = 1'b0;
        end
        half();
        cs = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        rst  = 1'b1;
        cs   = 1'b1;
        sck  = 1'b0;
        mosi = 1'b0;
        fork
            monitor();
        join_none
        repeat (3) @(negedge clk);
        check("rst_frame_done", {31'h0, frame_done}, 32'h0);
        check("rst_frame_cmd", {24'h0, frame_cmd}, 32'h0);
        check("rst_miso", {31'h0, miso}, 32'h0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Write then read back.
        push(8'h02, 1'b0, 32'h0, 1'b0);
        spi_frame(8'h02, 24'h000003, 32'h789abcde, 64, -1);
        push(8'h03, 1'b1, 32'h789abcde, 1'b0);
        spi_frame(8'h03, 24'h000003, 32'h0, 64, -1);

        // Upper address bits alias onto word 3.
        push(8'h02, 1'b0, 32'h0, 1'b0);
        spi_frame(8'h02, 24'h000013, 32'h56789abc, 64, -1);
        push(8'h03, 1'b1, 32'h56789abc, 1'b0);
        spi_frame(8'h03, 24'h000003, 32'h0, 64, -1);

        // Unknown command: completes, writes nothing, miso stays idle.
        push(8'ha5, 1'b0, 32'h0, 1'b1);
        spi_frame(8'ha5, 24'h123456, 32'h789abcde, 64, -1);
        push(8'h03, 1'b1, 32'h0, 1'b0);
        spi_frame(8'h03, 24'h000006, 32'h0, 64, -1);
        push(8'h03, 1'b1, 32'h56789abc, 1'b0);
        spi_frame(8'h03, 24'h000003, 32'h0, 64, -1);

        // Aborted write after 40 bits leaves word 5 untouched.
        spi_frame(8'h02, 24'h000005, 32'hdeadbeef, 40, -1);
        push(8'h03, 1'b1, 32'h0, 1'b0);
        spi_frame(8'h03, 24'h000005, 32'h0, 64, -1);

        // Reset pulse during the data phase of a read.
        spi_frame(8'h03, 24'h000003, 32'h0, 48, 40);
        check("post_rst_frame_cmd", {24'h0, frame_cmd}, 32'h0);
        check("post_rst_frame_done", {31'h0, frame_done}, 32'h0);
        check("post_rst_miso", {31'h0, miso}, 32'h0);
        push(8'h03, 1'b1, 32'h0, 1'b0);
        spi_frame(8'h03, 24'h000003, 32'h0, 64, -1);

        // Back-to-back frames; only the first one is a write.
        push(8'h02, 1'b0, 32'h0, 1'b0);
        spi_frame(8'h02, 24'h000007, 32'hcafef00d, 64, -1);
        push(8'h00, 1'b0, 32'h0, 1'b0);
        spi_frame(8'h00, 24'h000007, 32'h11111111, 64, -1);
        push(8'hff, 1'b0, 32'h0, 1'b0);
        spi_frame(8'hff, 24'h000007, 32'h22222222, 64, -1);
        push(8'h03, 1'b1, 32'hcafef00d, 1'b0);
        spi_frame(8'h03, 24'h000007, 32'h0, 64, -1);

        for (int k = 0; k < 200 && sb.size() != 0; k++) @(negedge clk);
        check("scoreboard_drained", sb.size(), 32'h0);
        repeat (10) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
